// File: rtl/fir_rr_scheduler_if.sv
// Bundle between the per-channel sample sources, the shared FIR block and the result sink.
// Carries the grant-statistics read port only when FIR_RR_SCHEDULER_STATS_EN is defined.
interface fir_rr_scheduler_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned WD_IN  = 24,
    parameter int unsigned WD_OUT = 24
);
    localparam int unsigned CW = $clog2(NUM_CH);

    logic [NUM_CH-1:0]       ch_valid;
    logic [NUM_CH*WD_IN-1:0] ch_data;
    logic [NUM_CH-1:0]       ch_ready;
    logic                    flush;
    logic                    fir_en;
    logic [WD_IN-1:0]        fir_din;
    logic [WD_OUT-1:0]       fir_dout;
    logic                    out_valid;
    logic [CW-1:0]           out_ch;
    logic [WD_OUT-1:0]       out_data;
    logic                    busy;
    logic                    flush_done;
`ifdef FIR_RR_SCHEDULER_STATS_EN
    logic [CW-1:0]           stat_sel;
    logic [15:0]             stat_cnt;
    logic                    stat_ovf;

    modport slave (
        input  ch_valid, ch_data, flush, fir_dout, stat_sel,
        output ch_ready, fir_en, fir_din, out_valid, out_ch, out_data, busy, flush_done,
               stat_cnt, stat_ovf
    );
    modport master (
        output ch_valid, ch_data, flush, fir_dout, stat_sel,
        input  ch_ready, fir_en, fir_din, out_valid, out_ch, out_data, busy, flush_done,
               stat_cnt, stat_ovf
    );
`else
    modport slave (
        input  ch_valid, ch_data, flush, fir_dout,
        output ch_ready, fir_en, fir_din, out_valid, out_ch, out_data, busy, flush_done
    );
    modport master (
        output ch_valid, ch_data, flush, fir_dout,
        input  ch_ready, fir_en, fir_din, out_valid, out_ch, out_data, busy, flush_done
    );
`endif
endinterface

// File: rtl/fir_rr_scheduler.sv
// Round-robin scheduler sharing one fixed-latency FIR datapath among NUM_CH sample sources.
// Define FIR_RR_SCHEDULER_STATS_EN to add saturating per-channel grant counters.
module fir_rr_scheduler #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned WD_IN     = 24,
    parameter int unsigned WD_OUT    = 24,
    parameter int unsigned FIR_LAT   = 3,
    parameter int unsigned ISSUE_GAP = 2
) (
    input logic               clk,
    input logic               reset,
    fir_rr_scheduler_if.slave bus
);
    localparam int unsigned CW = $clog2(NUM_CH);

    typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

    state_e             st_q;
    logic [CW-1:0]      ptr_q;
    logic [7:0]         gap_q;
    logic               fir_en_q;
    logic [WD_IN-1:0]   fir_din_q;
    logic [CW-1:0]      issue_ch_q;
    logic [FIR_LAT-1:0] tag_vld_q;
    logic [CW-1:0]      tag_ch_q [FIR_LAT];
    logic               out_valid_q;
    logic [CW-1:0]      out_ch_q;
    logic [WD_OUT-1:0]  out_data_q;
    logic               flush_done_q;
    logic               flush_arm_q;

    logic               flush_go;
    logic [NUM_CH-1:0]  grant;
    logic [CW-1:0]      grant_ch;
    logic               xfer;
    int unsigned        idx;

    // A flush that stays high across a drain must fall before it can start another one.
    assign flush_go = bus.flush & flush_arm_q;

    // Scan downwards so the channel closest after the pointer is written last and wins.
    always_comb begin
        grant    = '0;
        grant_ch = '0;
        idx      = 0;
        if (st_q == StRun && gap_q == 8'd0 && !flush_go) begin
            for (int unsigned k = NUM_CH; k >= 1; k--) begin
                idx = (32'(ptr_q) + k) % NUM_CH;
                if (bus.ch_valid[idx[CW-1:0]]) begin
                    grant                = '0;
                    grant[idx[CW-1:0]]   = 1'b1;
                    grant_ch             = idx[CW-1:0];
                end
            end
        end
    end

    assign xfer           = |grant;
    assign bus.ch_ready   = grant;
    assign bus.fir_en     = fir_en_q;
    assign bus.fir_din    = fir_din_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_ch     = out_ch_q;
    assign bus.out_data   = out_data_q;
    assign bus.flush_done = flush_done_q;
    assign bus.busy       = (|tag_vld_q) | fir_en_q | (st_q != StRun);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q         <= StRun;
            ptr_q        <= CW'(NUM_CH - 1);
            gap_q        <= 8'd0;
            fir_en_q     <= 1'b0;
            fir_din_q    <= '0;
            issue_ch_q   <= '0;
            tag_vld_q    <= '0;
            for (int i = 0; i < FIR_LAT; i++) tag_ch_q[i] <= '0;
            out_valid_q  <= 1'b0;
            out_ch_q     <= '0;
            out_data_q   <= '0;
            flush_done_q <= 1'b0;
            flush_arm_q  <= 1'b1;
        end else begin
            flush_done_q <= 1'b0;
            if (!bus.flush) flush_arm_q <= 1'b1;
            case (st_q)
                StRun: begin
                    if (flush_go) begin
                        st_q        <= StDrain;
                        flush_arm_q <= 1'b0;
                    end
                end
                StDrain: begin
                    if (tag_vld_q == '0 && !fir_en_q) st_q <= StDone;
                end
                StDone: begin
                    st_q         <= StRun;
                    flush_done_q <= 1'b1;
                end
                default: st_q <= StRun;
            endcase

            if (xfer) gap_q <= 8'(ISSUE_GAP - 1);
            else if (gap_q != 8'd0) gap_q <= gap_q - 8'd1;

            fir_en_q <= xfer;
            if (xfer) begin
                fir_din_q  <= bus.ch_data[32'(grant_ch) * WD_IN +: WD_IN];
                issue_ch_q <= grant_ch;
                ptr_q      <= grant_ch;
            end

            tag_vld_q[0] <= fir_en_q;
            tag_ch_q[0]  <= issue_ch_q;
            for (int i = 1; i < FIR_LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_ch_q[i]  <= tag_ch_q[i-1];
            end

            out_valid_q <= tag_vld_q[FIR_LAT-1];
            if (tag_vld_q[FIR_LAT-1]) begin
                out_ch_q   <= tag_ch_q[FIR_LAT-1];
                out_data_q <= bus.fir_dout;
            end
        end
    end

`ifdef FIR_RR_SCHEDULER_STATS_EN
    logic [15:0] stat_q [NUM_CH];
    logic [15:0] stat_cnt_q;
    logic        stat_ovf_q;

    assign bus.stat_cnt = stat_cnt_q;
    assign bus.stat_ovf = stat_ovf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) stat_q[i] <= '0;
            stat_cnt_q <= '0;
            stat_ovf_q <= 1'b0;
        end else begin
            if (xfer) begin
                if (stat_q[grant_ch] != 16'hFFFF) stat_q[grant_ch] <= stat_q[grant_ch] + 16'd1;
                if (stat_q[grant_ch] >= 16'hFFFE) stat_ovf_q <= 1'b1;
            end
            stat_cnt_q <= (32'(bus.stat_sel) < NUM_CH) ? stat_q[bus.stat_sel] : 16'd0;
        end
    end
`endif
endmodule

// File: tb/tb_fir_rr_scheduler.sv
// Directed table-driven bench for fir_rr_scheduler with a simple external FIR model.
// Extra grant-counter checks run when FIR_RR_SCHEDULER_STATS_EN is defined.
module tb_fir_rr_scheduler;
    localparam int unsigned NUM_CH    = 4;
    localparam int unsigned WD_IN     = 24;
    localparam int unsigned WD_OUT    = 24;
    localparam int unsigned FIR_LAT   = 3;
    localparam int unsigned ISSUE_GAP = 2;

    // FIR model: result = sample ^ K, FIR_LAT clocks after fir_en.
    localparam logic [23:0] K  = 24'h5A5A5A;
    localparam logic [23:0] D0 = 24'h000123, D1 = 24'h222222, D2 = 24'h333333, D3 = 24'h444444;
    localparam int R0 = 'h5A5B79, R1 = 'h787878, R2 = 'h696969, R3 = 'h1E1E1E;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fir_rr_scheduler_if #(.NUM_CH(NUM_CH), .WD_IN(WD_IN), .WD_OUT(WD_OUT)) bus ();

    fir_rr_scheduler #(
        .NUM_CH(NUM_CH), .WD_IN(WD_IN), .WD_OUT(WD_OUT), .FIR_LAT(FIR_LAT), .ISSUE_GAP(ISSUE_GAP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    logic [WD_OUT-1:0] fir_pipe [FIR_LAT];
    always @(posedge clk) begin
        fir_pipe[0] <= bus.fir_en ? (bus.fir_din ^ K) : 24'h0;
        for (int i = 1; i < FIR_LAT; i++) fir_pipe[i] <= fir_pipe[i-1];
    end
    assign bus.fir_dout = fir_pipe[FIR_LAT-1];

`ifdef FIR_RR_SCHEDULER_STATS_EN
    fir_rr_scheduler_if #(.NUM_CH(NUM_CH), .WD_IN(WD_IN), .WD_OUT(WD_OUT)) bus2 ();

    fir_rr_scheduler #(
        .NUM_CH(NUM_CH), .WD_IN(WD_IN), .WD_OUT(WD_OUT), .FIR_LAT(FIR_LAT), .ISSUE_GAP(1)
    ) dut2 (
        .clk(clk),
        .reset(reset),
        .bus(bus2)
    );

    assign bus.stat_sel  = '0;
    assign bus2.fir_dout = '0;
`endif

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic        fl;
        logic [3:0]  rdy;
        logic        en;
        logic [23:0] din;
        logic        ov;
        logic [1:0]  och;
        logic [23:0] od;
        logic        busy;
        logic        fd;
    } vec_t;

    vec_t tv[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   lat;

    task automatic check(input string name, input int row, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s (row %0d): got %0h, expected %0h", name, row, act, exp);
        end
    endtask

    task automatic add(input int rst, input int v, input int fl, input int rdy, input int en,
                       input int din, input int ov, input int och, input int od,
                       input int b, input int fd);
        tv.push_back('{1'(rst), 4'(v), 1'(fl), 4'(rdy), 1'(en), 24'(din), 1'(ov), 2'(och),
                       24'(od), 1'(b), 1'(fd)});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        bus.ch_valid = '0;
        bus.flush    = 1'b0;
        bus.ch_data  = {D3, D2, D1, D0};
`ifdef FIR_RR_SCHEDULER_STATS_EN
        bus2.ch_valid = '0;
        bus2.flush    = 1'b0;
        bus2.ch_data  = {D3, D2, D1, D0};
        bus2.stat_sel = '0;
`endif

        //  rst v    fl rdy en din ov och od  busy fd
        add(1, 0,   0, 0,  0, 0,  0, 0, 0,  0, 0);
        // single sample on channel 0
        add(0, 'h1, 0, 1,  0, 0,  0, 0, 0,  0, 0);
        add(0, 0,   0, 0,  1, D0, 0, 0, 0,  1, 0);
        add(0, 0,   0, 0,  0, 0,  0, 0, 0,  1, 0);
        add(0, 0,   0, 0,  0, 0,  0, 0, 0,  1, 0);
        add(0, 0,   0, 0,  0, 0,  0, 0, 0,  1, 0);
        add(0, 0,   0, 0,  0, 0,  1, 0, R0, 0, 0);
        add(0, 0,   0, 0,  0, 0,  0, 0, R0, 0, 0);
        add(1, 0,   0, 0,  0, 0,  0, 0, 0,  0, 0);
        // all channels valid: grants 0,1,2,3,0 two cycles apart
        add(0, 'hF, 0, 1,  0, 0,  0, 0, 0,  0, 0);
        add(0, 'hF, 0, 0,  1, D0, 0, 0, 0,  1, 0);
        add(0, 'hF, 0, 2,  0, 0,  0, 0, 0,  1, 0);
        add(0, 'hF, 0, 0,  1, D1, 0, 0, 0,  1, 0);
        add(0, 'hF, 0, 4,  0, 0,  0, 0, 0,  1, 0);
        add(0, 'hF, 0, 0,  1, D2, 1, 0, R0, 1, 0);
        add(0, 'hF, 0, 8,  0, 0,  0, 0, R0, 1, 0);
        add(0, 'hF, 0, 0,  1, D3, 1, 1, R1, 1, 0);
        add(0, 'hF, 0, 1,  0, 0,  0, 0, R1, 1, 0);
        add(0, 'hF, 0, 0,  1, D0, 1, 2, R2, 1, 0);
        add(0, 0,   0, 0,  0, 0,  0, 0, R2, 1, 0);
        add(0, 0,   0, 0,  0, 0,  1, 3, R3, 1, 0);
        add(0, 0,   0, 0,  0, 0,  0, 0, R3, 1, 0);
        add(0, 0,   0, 0,  0, 0,  1, 0, R0, 0, 0);
        add(1, 0,   0, 0,  0, 0,  0, 0, 0,  0, 0);
        // channels 1 and 3: 1, 3, then wrap to 1
        add(0, 'hA, 0, 2,  0, 0,  0, 0, 0,  0, 0);
        add(0, 'hA, 0, 0,  1, D1, 0, 0, 0,  1, 0);
        add(0, 'hA, 0, 8,  0, 0,  0, 0, 0,  1, 0);
        add(0, 'hA, 0, 0,  1, D3, 0, 0, 0,  1, 0);
        add(0, 'hA, 0, 2,  0, 0,  0, 0, 0,  1, 0);
        add(0, 0,   0, 0,  1, D1, 1, 1, R1, 1, 0);
        add(0, 0,   0, 0,  0, 0,  0, 0, R1, 1, 0);
        add(0, 0,   0, 0,  0, 0,  1, 3, R3, 1, 0);
        add(0, 0,   0, 0,  0, 0,  0, 0, R3, 1, 0);
        add(0, 0,   0, 0,  0, 0,  1, 1, R1, 0, 0);
        add(1, 0,   0, 0,  0, 0,  0, 0, 0,  0, 0);
        // flush with two samples in flight; flush held high is ignored after the drain
        add(0, 'h1, 0, 1,  0, 0,  0, 0, 0,  0, 0);
        add(0, 'h2, 0, 0,  1, D0, 0, 0, 0,  1, 0);
        add(0, 'h2, 0, 2,  0, 0,  0, 0, 0,  1, 0);
        add(0, 'h4, 0, 0,  1, D1, 0, 0, 0,  1, 0);
        add(0, 'h4, 1, 0,  0, 0,  0, 0, 0,  1, 0);
        add(0, 'h4, 1, 0,  0, 0,  1, 0, R0, 1, 0);
        add(0, 'h4, 1, 0,  0, 0,  0, 0, R0, 1, 0);
        add(0, 'h4, 1, 0,  0, 0,  1, 1, R1, 1, 0);
        add(0, 'h4, 1, 0,  0, 0,  0, 0, R1, 1, 0);
        add(0, 'h4, 1, 4,  0, 0,  0, 0, R1, 0, 1);
        add(0, 0,   0, 0,  1, D2, 0, 0, R1, 1, 0);
        // reset one cycle after fir_en: sample dropped, channel 0 first again
        add(1, 0,   0, 0,  0, 0,  0, 0, 0,  0, 0);
        add(0, 'hF, 0, 1,  0, 0,  0, 0, 0,  0, 0);
        add(0, 0,   0, 0,  1, D0, 0, 0, 0,  1, 0);
        add(0, 0,   0, 0,  0, 0,  0, 0, 0,  1, 0);
        add(0, 0,   0, 0,  0, 0,  0, 0, 0,  1, 0);
        add(0, 0,   0, 0,  0, 0,  0, 0, 0,  1, 0);
        add(0, 0,   0, 0,  0, 0,  1, 0, R0, 0, 0);

        foreach (tv[i]) begin
            @(posedge clk); #1;
            reset        = tv[i].rst;
            bus.ch_valid = tv[i].v;
            bus.flush    = tv[i].fl;
            @(negedge clk);
            check("ch_ready", i, int'(bus.ch_ready), int'(tv[i].rdy));
            check("fir_en", i, int'(bus.fir_en), int'(tv[i].en));
            if (tv[i].en) check("fir_din", i, int'(bus.fir_din), int'(tv[i].din));
            check("out_valid", i, int'(bus.out_valid), int'(tv[i].ov));
            if (tv[i].ov) check("out_ch", i, int'(bus.out_ch), int'(tv[i].och));
            check("out_data", i, int'(bus.out_data), int'(tv[i].od));
            check("busy", i, int'(bus.busy), int'(tv[i].busy));
            check("flush_done", i, int'(bus.flush_done), int'(tv[i].fd));
        end

        // Channel 3 alone: result 5 cycles after the handshake, bounded wait.
        @(posedge clk); #1;
        bus.ch_valid = 4'b1000;
        @(negedge clk);
        check("seq_ready_ch3", 100, int'(bus.ch_ready), 'h8);
        @(posedge clk); #1;
        bus.ch_valid = '0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("seq_latency", 101, lat, 5);
        check("seq_out_ch", 102, int'(bus.out_ch), 3);
        check("seq_out_data", 103, int'(bus.out_data), R3);

        // Flush with nothing in flight: RUN -> DRAIN -> DONE -> one-cycle flush_done.
        @(posedge clk); #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("idle_flush_busy", 104, int'(bus.busy), 1);
        lat = 1;
        while (!bus.flush_done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("idle_flush_latency", 105, lat, 3);
        check("idle_flush_busy_done", 106, int'(bus.busy), 0);
        @(posedge clk); #1;
        check("idle_flush_pulse", 107, int'(bus.flush_done), 0);

`ifdef FIR_RR_SCHEDULER_STATS_EN
        // Back-to-back grants to channel 2 well past saturation.
        @(posedge clk); #1;
        bus2.ch_valid = 4'b0100;
        repeat (70000) @(posedge clk);
        #1;
        bus2.ch_valid = '0;
        bus2.stat_sel = 2'd2;
        @(posedge clk);
        @(posedge clk); #1;
        check("stat_cnt_ch2", 200, int'(bus2.stat_cnt), 'hFFFF);
        check("stat_ovf", 201, int'(bus2.stat_ovf), 1);
        bus2.stat_sel = 2'd0;
        @(posedge clk); #1;
        check("stat_cnt_ch0", 202, int'(bus2.stat_cnt), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
